frame_dma_mc: RTL and testbench
===============================

Name: frame_dma_mc

Overview:
Multi-channel successor to the single-channel capture DMA. Accepts NUM_CH independent byte streams, such as camera pixels and a second sensor or audio path. Each channel buffers its stream in a small per-channel FIFO and round-robin arbitrates onto one shared SRAM write port with backpressure. Each channel supports one-shot or ring (circular buffer) mode and has per-channel done, overflow and wrap status for the CSR and IRQ logic.

Parameters:
NUM_CH, 2, number of independent channels (1..8)
DATA_W, 8, stream and write data width in bits
ADDR_W, 16, write address and length width in bits
FIFO_DEPTH, 4, per-channel FIFO entries (power of two, >=2)

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
start  in  NUM_CH  per-channel start pulse
abort  in  NUM_CH  per-channel abort pulse
ring_mode  in  NUM_CH  1 = circular buffer, 0 = one-shot; sampled at start
ch_base  in  NUM_CH*ADDR_W  per-channel base address; slice c = [c*ADDR_W +: ADDR_W]
ch_len  in  NUM_CH*ADDR_W  per-channel length in beats
in_valid  in  NUM_CH  stream beat valid; no ready, source cannot stall
in_sof  in  NUM_CH  start-of-frame marker, qualified by in_valid
in_data  in  NUM_CH*DATA_W  stream data
wr_valid  out  1  write request
wr_ready  in  1  SRAM accepts write
wr_addr  out  ADDR_W  write address
wr_data  out  DATA_W  write data
wr_ch  out  $clog2(NUM_CH) (min 1)  channel owning the write
busy  out  NUM_CH  channel in ARMED or RUN
done  out  NUM_CH  sticky one-shot completion; cleared by start or abort
done_pulse  out  NUM_CH  one-cycle pulse on completion or on each ring wrap
overflow  out  NUM_CH  sticky: beat dropped because FIFO was full
wrap_count  out  NUM_CH*8  per-channel ring wraps, saturating at 255
bytes_written  out  NUM_CH*ADDR_W  per-channel beats accepted by SRAM since start or last wrap

Behaviour:
- Reset: all channels IDLE, FIFOs empty, all outputs 0.
- Per-channel FSM states: IDLE, ARMED, RUN, DONE.
- IDLE/DONE + start:
  - Latch base, len and ring_mode.
  - Clear done, overflow, wrap_count and bytes_written.
  - Go to ARMED.
  - If latched len==0: go to DONE instead, pulse done_pulse next cycle, set done.
- ARMED/RUN + start: ignored.
- abort in any state: go to IDLE next cycle, flush FIFO, clear done. If that channel owns a pending wr_valid beat, withdraw it next cycle. abort beats a simultaneous start.
- ARMED: beats without sof are dropped (no overflow). in_valid && in_sof pushes the beat and moves to RUN.
- RUN push rules:
  - Each in_valid beat is pushed while pushed_count < len.
  - In one-shot mode, beats after len are dropped silently.
  - In RUN, in_sof is ignored.
  - If the FIFO is full on in_valid, drop the beat, set overflow; the beat does not count toward len.
  - A simultaneous push and pop on a full FIFO is allowed.
- Address: wr_addr = base + offset, modulo 2^ADDR_W. offset increments on each wr_valid && wr_ready for that channel.
- One-shot completion: when the len-th beat is accepted (wr_ready), go to DONE, set done, pulse done_pulse in the same cycle as acceptance+1.
- Ring mode: when the len-th beat is accepted:
  - offset and bytes_written return to 0.
  - wrap_count increments (saturating) and done_pulse fires.
  - The channel stays in RUN; push count resets, so streaming continues without a gap.
  - The channel runs until abort.
- Write port:
  - Single registered output stage.
  - wr_valid, wr_addr, wr_data and wr_ch stay stable while wr_valid && !wr_ready.
  - A new beat loads when the stage is empty or is being accepted this cycle, giving a sustained 1 beat/cycle.
- Arbiter: round-robin over channels with a non-empty FIFO. Search starts at last_grant+1 mod NUM_CH; last_grant updates only on a load. With one requester, that requester wins every cycle.
- Latency: in_valid beat into an empty FIFO with an idle port gives wr_valid 2 cycles later (FIFO write, then output register).
- NUM_CH==1: the arbiter degenerates and wr_ch is tied to 0.

Decomposition:
- Package frame_dma_pkg:
  - ch_state_e (IDLE, ARMED, RUN, DONE).
  - The CH_W = max(1, $clog2(NUM_CH)) helper function.
  - The WRAP_CNT_W=8 constant.
- Sub-module sync_fifo (parametrised DATA_W, DEPTH): push/pop/full/empty/flush; instantiated once per channel in a generate loop.
- The arbiter stays inline.

Test Plan:
1. Ch0 base=0x0100, len=4, one-shot, wr_ready=1; 6 beats from sof (0xA0..0xA5). Writes 0x0100..0x0103 = A0..A3; done_pulse once; done=1; bytes_written=4; A4/A5 dropped; overflow=0.
2. Ch0 and ch1 both streaming every cycle, wr_ready=1, FIFO_DEPTH=4. wr_ch alternates 0,1,0,1. Each channel writes one beat per 2 cycles, so the FIFOs fill and overflow sets on both. Bytes_written ends equal to beats accepted.
3. wr_ready=0 for 10 cycles while ch0 streams 8 beats. wr_* held stable; 4 FIFO beats plus 1 register beat are kept; overflow[0]=1. After release the writes resume in order with no duplicates.
4. Ring mode, base=0xFFFE, len=3, 7 beats. Addresses 0xFFFE, 0xFFFF, 0x0000, then 0xFFFE...; wrap_count=2; two done_pulses; done stays 0; busy stays 1.
5. Abort ch1 mid-frame while its beat is held at wr_valid with wr_ready=0. wr_valid drops next cycle; ch1 goes IDLE with an empty FIFO. Ch0 is unaffected; start and abort in the same cycle leaves ch1 IDLE.
6. start with len=0 gives done_pulse the next cycle, done=1, no writes. Beats without sof in ARMED produce no writes.

Source files
------------

// File: rtl/frame_dma_pkg.sv
// Shared types and helpers for the multi-channel frame capture DMA.
package frame_dma_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    RUN   = 2'd2,
    DONE  = 2'd3
  } ch_state_e;

  localparam int WRAP_CNT_W = 8;

  // Channel-index width; a single channel still needs a 1-bit wr_ch.
  function automatic int ch_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/frame_dma_mc_fifo.sv
// Small synchronous FIFO with flush; a push into a full FIFO is accepted
// only when a pop happens in the same cycle.
module sync_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout,
  output logic              full,
  output logic              empty
);

  localparam int AW = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic [AW:0]       count;
  logic              do_push, do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign dout    = mem[rd_ptr];
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  // Pointer and occupancy bookkeeping; flush empties the FIFO in one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage array, written only on an accepted push.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/frame_dma_mc.sv
// Multi-channel capture DMA: per-channel stream FIFOs, round-robin onto a
// single registered SRAM write port, one-shot or ring buffering per channel.
//
// Per-channel FSM:
//   state | meaning
//   IDLE  | inactive, waiting for start
//   ARMED | started, waiting for a beat carrying sof
//   RUN   | capturing beats and writing them out
//   DONE  | one-shot frame fully written, waiting for start
module frame_dma_mc
  import frame_dma_pkg::*;
#(
  parameter int NUM_CH     = 2,
  parameter int DATA_W     = 8,
  parameter int ADDR_W     = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NUM_CH-1:0]            start,
  input  logic [NUM_CH-1:0]            abort,
  input  logic [NUM_CH-1:0]            ring_mode,
  input  logic [NUM_CH*ADDR_W-1:0]     ch_base,
  input  logic [NUM_CH*ADDR_W-1:0]     ch_len,
  input  logic [NUM_CH-1:0]            in_valid,
  input  logic [NUM_CH-1:0]            in_sof,
  input  logic [NUM_CH*DATA_W-1:0]     in_data,
  output logic                         wr_valid,
  input  logic                         wr_ready,
  output logic [ADDR_W-1:0]            wr_addr,
  output logic [DATA_W-1:0]            wr_data,
  output logic [ch_w(NUM_CH)-1:0]      wr_ch,
  output logic [NUM_CH-1:0]            busy,
  output logic [NUM_CH-1:0]            done,
  output logic [NUM_CH-1:0]            done_pulse,
  output logic [NUM_CH-1:0]            overflow,
  output logic [NUM_CH*WRAP_CNT_W-1:0] wrap_count,
  output logic [NUM_CH*ADDR_W-1:0]     bytes_written
);

  localparam int CH_W = ch_w(NUM_CH);

  logic [NUM_CH-1:0] req, pop, fifo_empty;
  logic [DATA_W-1:0] fifo_dout [NUM_CH];
  logic [ADDR_W-1:0] ld_addr   [NUM_CH];
  logic [CH_W-1:0]   last_grant, grant, grant_hi, grant_lo;
  logic              found_hi, found_lo, grant_ok, stage_free;

  // An aborted owner frees the output stage just like an acceptance does.
  assign stage_free = !wr_valid || wr_ready || abort[wr_ch];

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    ch_state_e             state_q, state_d;
    logic [ADDR_W-1:0]     base_q, len_q, push_cnt_q, issue_off_q, bytes_q;
    logic [ADDR_W-1:0]     start_len;
    logic [WRAP_CNT_W-1:0] wrap_q;
    logic                  ring_q, done_q, ovf_q, pulse_q;
    logic                  start_ok, in_active, attempt, fifo_push, fifo_full;
    logic                  drop, acc, last_acc;

    assign start_len = ch_len[c*ADDR_W +: ADDR_W];
    assign acc       = wr_valid && wr_ready && (wr_ch == CH_W'(c)) && !abort[c];
    assign req[c]    = !fifo_empty[c] && !abort[c];
    assign ld_addr[c] = base_q + issue_off_q;

    sync_fifo #(
      .DATA_W (DATA_W),
      .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .flush (abort[c]),
      .push  (fifo_push),
      .pop   (pop[c]),
      .din   (in_data[c*DATA_W +: DATA_W]),
      .dout  (fifo_dout[c]),
      .full  (fifo_full),
      .empty (fifo_empty[c])
    );

    // Channel state register.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
    end

    // Next-state: abort dominates, len==0 completes immediately.
    always_comb begin
      state_d = state_q;
      if (abort[c]) begin
        state_d = IDLE;
      end else begin
        case (state_q)
          IDLE, DONE: if (start[c]) state_d = (start_len == '0) ? DONE : ARMED;
          ARMED:      if (fifo_push) state_d = RUN;
          RUN:        if (last_acc && !ring_q) state_d = DONE;
          default:    state_d = IDLE;
        endcase
      end
    end

    // Per-state qualification of start, incoming beats and completion.
    always_comb begin
      start_ok  = 1'b0;
      in_active = 1'b0;
      case (state_q)
        IDLE, DONE: start_ok  = start[c] && !abort[c];
        ARMED:      in_active = in_sof[c];
        RUN:        in_active = ring_q || (push_cnt_q < len_q);
        default:    in_active = 1'b0;
      endcase
      attempt   = in_valid[c] && in_active && !abort[c];
      fifo_push = attempt && (!fifo_full || pop[c]);
      drop      = attempt && fifo_full && !pop[c];
      last_acc  = acc && (state_q == RUN) && (bytes_q == len_q - ADDR_W'(1));
    end

    // Latched configuration, counters and sticky status.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        base_q      <= '0;
        len_q       <= '0;
        ring_q      <= 1'b0;
        push_cnt_q  <= '0;
        issue_off_q <= '0;
        bytes_q     <= '0;
        wrap_q      <= '0;
        done_q      <= 1'b0;
        ovf_q       <= 1'b0;
        pulse_q     <= 1'b0;
      end else begin
        pulse_q <= 1'b0;
        if (abort[c]) begin
          done_q      <= 1'b0;
          push_cnt_q  <= '0;
          issue_off_q <= '0;
        end else if (start_ok) begin
          base_q      <= ch_base[c*ADDR_W +: ADDR_W];
          len_q       <= start_len;
          ring_q      <= ring_mode[c];
          push_cnt_q  <= '0;
          issue_off_q <= '0;
          bytes_q     <= '0;
          wrap_q      <= '0;
          ovf_q       <= 1'b0;
          done_q      <= (start_len == '0);
          pulse_q     <= (start_len == '0);
        end else begin
          if (fifo_push)
            push_cnt_q <= (ring_q && push_cnt_q == len_q - ADDR_W'(1)) ? '0
                                                                       : push_cnt_q + ADDR_W'(1);
          if (drop) ovf_q <= 1'b1;
          // Address offset advances at load time so back-to-back beats of one
          // channel get consecutive addresses before the earlier one is accepted.
          if (pop[c])
            issue_off_q <= (ring_q && issue_off_q == len_q - ADDR_W'(1)) ? '0
                                                                         : issue_off_q + ADDR_W'(1);
          if (last_acc) begin
            pulse_q <= 1'b1;
            if (ring_q) begin
              bytes_q <= '0;
              if (wrap_q != '1) wrap_q <= wrap_q + WRAP_CNT_W'(1);
            end else begin
              bytes_q <= bytes_q + ADDR_W'(1);
              done_q  <= 1'b1;
            end
          end else if (acc) begin
            bytes_q <= bytes_q + ADDR_W'(1);
          end
        end
      end
    end

    assign busy[c]       = (state_q == ARMED) || (state_q == RUN);
    assign done[c]       = done_q;
    assign done_pulse[c] = pulse_q;
    assign overflow[c]   = ovf_q;
    assign wrap_count[c*WRAP_CNT_W +: WRAP_CNT_W] = wrap_q;
    assign bytes_written[c*ADDR_W +: ADDR_W]      = bytes_q;
  end

  // Round-robin pick: lowest requester above last_grant, else lowest overall.
  always_comb begin
    found_hi = 1'b0;
    found_lo = 1'b0;
    grant_hi = '0;
    grant_lo = '0;
    for (int c = NUM_CH - 1; c >= 0; c--) begin
      if (req[c]) begin
        if (c > int'(last_grant)) begin
          found_hi = 1'b1;
          grant_hi = CH_W'(c);
        end else begin
          found_lo = 1'b1;
          grant_lo = CH_W'(c);
        end
      end
    end
    grant_ok = found_hi || found_lo;
    grant    = found_hi ? grant_hi : grant_lo;
    pop      = '0;
    if (grant_ok && stage_free) pop[grant] = 1'b1;
  end

  // Registered write stage; holds while stalled, reloads on accept or abort.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_valid   <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
      wr_ch      <= '0;
      last_grant <= CH_W'(NUM_CH - 1);
    end else if (stage_free) begin
      wr_valid <= grant_ok;
      if (grant_ok) begin
        wr_addr    <= ld_addr[grant];
        wr_data    <= fifo_dout[grant];
        wr_ch      <= (NUM_CH == 1) ? '0 : grant;
        last_grant <= grant;
      end
    end
  end

endmodule

// File: tb/tb_frame_dma_mc.sv
// Directed bench for frame_dma_mc with two channels.
module tb_frame_dma_mc;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  start, abort, ring_mode, in_valid, in_sof;
  logic [31:0] ch_base, ch_len;
  logic [15:0] in_data;
  logic        wr_valid, wr_ready;
  logic [15:0] wr_addr;
  logic [7:0]  wr_data;
  logic [0:0]  wr_ch;
  logic [1:0]  busy, done, done_pulse, overflow;
  logic [15:0] wrap_count;
  logic [31:0] bytes_written;

  int checks = 0;
  int errors = 0;

  // Write log and done_pulse counters, each written only by the monitor.
  logic [15:0] log_addr [128];
  logic [7:0]  log_data [128];
  logic [0:0]  log_ch   [128];
  int          log_n = 0;
  int          dp0 = 0, dp1 = 0;

  frame_dma_mc #(.NUM_CH(2), .DATA_W(8), .ADDR_W(16), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .ring_mode(ring_mode),
    .ch_base(ch_base), .ch_len(ch_len), .in_valid(in_valid), .in_sof(in_sof),
    .in_data(in_data), .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr),
    .wr_data(wr_data), .wr_ch(wr_ch), .busy(busy), .done(done), .done_pulse(done_pulse),
    .overflow(overflow), .wrap_count(wrap_count), .bytes_written(bytes_written)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (wr_valid && wr_ready && log_n < 128) begin
      log_addr[log_n] <= wr_addr;
      log_data[log_n] <= wr_data;
      log_ch[log_n]   <= wr_ch;
      log_n           <= log_n + 1;
    end
    if (done_pulse[0]) dp0 <= dp0 + 1;
    if (done_pulse[1]) dp1 <= dp1 + 1;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cfg(input int c, input logic [15:0] base, input logic [15:0] len,
                     input logic ring);
    ch_base[c*16 +: 16] = base;
    ch_len[c*16 +: 16]  = len;
    ring_mode[c]        = ring;
  endtask

  task automatic pulse(input logic [1:0] s, input logic [1:0] a);
    start = s;
    abort = a;
    tick(1);
    start = '0;
    abort = '0;
  endtask

  initial begin
    int mark, dmark, n0, n1;
    logic [7:0]  d0_8, d1_7;
    logic [15:0] a0_last;
    logic [15:0] ring_addr [7];

    rst_n = 1'b0; start = '0; abort = '0; ring_mode = '0; in_valid = '0; in_sof = '0;
    ch_base = '0; ch_len = '0; in_data = '0; wr_ready = 1'b0;
    tick(3);
    rst_n = 1'b1;
    tick(1);
    chk("rst_wr_valid", wr_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_wrap", wrap_count, 0);
    chk("rst_bytes", bytes_written, 0);

    // One-shot, len 4, six beats offered.
    cfg(0, 16'h0100, 16'd4, 1'b0);
    wr_ready = 1'b1;
    mark = log_n; dmark = dp0;
    pulse(2'b01, 2'b00);
    chk("t1_busy_armed", busy, 2'b01);
    for (int k = 0; k < 6; k++) begin
      in_valid[0] = 1'b1;
      in_sof[0]   = (k == 0);
      in_data[7:0] = 8'hA0 + 8'(k);
      tick(1);
      if (k == 0) chk("t1_lat_not_yet", wr_valid, 0);
      if (k == 1) begin
        chk("t1_lat_valid", wr_valid, 1);
        chk("t1_lat_addr", wr_addr, 16'h0100);
        chk("t1_lat_data", wr_data, 8'hA0);
      end
    end
    in_valid = '0; in_sof = '0;
    tick(6);
    chk("t1_nwrites", log_n - mark, 4);
    for (int i = 0; i < 4; i++) begin
      chk("t1_addr", log_addr[mark+i], 16'h0100 + 16'(i));
      chk("t1_data", log_data[mark+i], 8'hA0 + 8'(i));
    end
    chk("t1_done_pulses", dp0 - dmark, 1);
    chk("t1_done", done[0], 1);
    chk("t1_bytes", bytes_written[15:0], 4);
    chk("t1_overflow", overflow[0], 0);
    chk("t1_busy", busy[0], 0);

    // len 0 completes immediately; sof-less beats in ARMED are ignored.
    cfg(1, 16'h0200, 16'd0, 1'b0);
    dmark = dp1;
    pulse(2'b10, 2'b00);
    chk("t6_pulse_now", done_pulse[1], 1);
    chk("t6_done", done[1], 1);
    chk("t6_busy", busy[1], 0);
    tick(1);
    chk("t6_pulse_gone", done_pulse[1], 0);
    chk("t6_pulse_count", dp1 - dmark, 1);
    cfg(1, 16'h0200, 16'd4, 1'b0);
    mark = log_n;
    pulse(2'b10, 2'b00);
    chk("t6_restart_clears_done", done[1], 0);
    for (int k = 0; k < 3; k++) begin
      in_valid[1] = 1'b1;
      in_data[15:8] = 8'h50 + 8'(k);
      tick(1);
    end
    in_valid = '0;
    tick(4);
    chk("t6_no_writes", log_n - mark, 0);
    chk("t6_still_armed", busy[1], 1);
    chk("t6_no_overflow", overflow[1], 0);
    pulse(2'b00, 2'b10);
    chk("t6_abort_idle", busy[1], 0);

    // Abort ch1 while its beat is stalled at the write port.
    cfg(1, 16'h0300, 16'd8, 1'b0);
    wr_ready = 1'b0;
    pulse(2'b10, 2'b00);
    for (int k = 0; k < 3; k++) begin
      in_valid[1] = 1'b1;
      in_sof[1]   = (k == 0);
      in_data[15:8] = 8'hC0 + 8'(k);
      tick(1);
    end
    in_valid = '0; in_sof = '0;
    tick(2);
    chk("t5_held_valid", wr_valid, 1);
    chk("t5_held_ch", wr_ch, 1);
    chk("t5_held_data", wr_data, 8'hC0);
    chk("t5_held_addr", wr_addr, 16'h0300);
    pulse(2'b00, 2'b10);
    chk("t5_withdrawn", wr_valid, 0);
    chk("t5_ch1_idle", busy[1], 0);
    chk("t5_ch0_done_kept", done[0], 1);
    wr_ready = 1'b1;
    cfg(1, 16'h0300, 16'd2, 1'b0);
    mark = log_n;
    pulse(2'b10, 2'b00);
    for (int k = 0; k < 2; k++) begin
      in_valid[1] = 1'b1;
      in_sof[1]   = (k == 0);
      in_data[15:8] = 8'hD0 + 8'(k);
      tick(1);
    end
    in_valid = '0; in_sof = '0;
    tick(6);
    chk("t5_flushed_nwrites", log_n - mark, 2);
    chk("t5_flushed_first", log_data[mark], 8'hD0);
    chk("t5_flushed_addr", log_addr[mark], 16'h0300);
    chk("t5_restart_done", done[1], 1);
    pulse(2'b10, 2'b10);
    chk("t5_start_abort_idle", busy[1], 0);
    chk("t5_start_abort_done", done[1], 0);

    // Both channels streaming every cycle; last grant was ch1.
    cfg(0, 16'h1000, 16'd16, 1'b0);
    cfg(1, 16'h2000, 16'd16, 1'b0);
    mark = log_n;
    pulse(2'b11, 2'b00);
    for (int k = 0; k < 12; k++) begin
      in_valid = 2'b11;
      in_sof   = (k == 0) ? 2'b11 : 2'b00;
      in_data  = {8'h80 + 8'(k), 8'(k)};
      tick(1);
    end
    in_valid = '0; in_sof = '0;
    tick(25);
    chk("t2_ch_0", log_ch[mark], 0);
    chk("t2_ch_1", log_ch[mark+1], 1);
    chk("t2_ch_2", log_ch[mark+2], 0);
    chk("t2_ch_3", log_ch[mark+3], 1);
    n0 = 0; n1 = 0; d0_8 = '0; d1_7 = '0; a0_last = '0;
    for (int i = mark; i < log_n; i++) begin
      if (log_ch[i] == 1'b0) begin
        if (n0 == 8) d0_8 = log_data[i];
        a0_last = log_addr[i];
        n0++;
      end else begin
        if (n1 == 7) d1_7 = log_data[i];
        n1++;
      end
    end
    chk("t2_n0", n0, 10);
    chk("t2_n1", n1, 9);
    chk("t2_ch0_after_drop", d0_8, 8'h09);
    chk("t2_ch1_after_drop", d1_7, 8'h88);
    chk("t2_ch0_last_addr", a0_last, 16'h1009);
    chk("t2_overflow", overflow, 2'b11);
    chk("t2_bytes0", bytes_written[15:0], 10);
    chk("t2_bytes1", bytes_written[31:16], 9);
    chk("t2_not_done", done, 2'b00);
    pulse(2'b00, 2'b11);
    chk("t2_abort_idle", busy, 2'b00);

    // Port stalled for 10 cycles while ch0 offers 8 beats.
    cfg(0, 16'h0400, 16'd8, 1'b0);
    wr_ready = 1'b0;
    mark = log_n;
    pulse(2'b01, 2'b00);
    for (int k = 0; k < 10; k++) begin
      in_valid[0] = (k < 8);
      in_sof[0]   = (k == 0);
      in_data[7:0] = 8'hE0 + 8'(k);
      tick(1);
      if (k >= 1) begin
        chk("t3_hold_valid", wr_valid, 1);
        chk("t3_hold_data", wr_data, 8'hE0);
        chk("t3_hold_addr", wr_addr, 16'h0400);
      end
    end
    in_valid = '0; in_sof = '0;
    chk("t3_overflow", overflow[0], 1);
    chk("t3_none_accepted", log_n - mark, 0);
    wr_ready = 1'b1;
    tick(8);
    chk("t3_nwrites", log_n - mark, 5);
    for (int i = 0; i < 5; i++) begin
      chk("t3_data", log_data[mark+i], 8'hE0 + 8'(i));
      chk("t3_addr", log_addr[mark+i], 16'h0400 + 16'(i));
    end
    chk("t3_bytes", bytes_written[15:0], 5);
    chk("t3_still_run", busy[0], 1);
    pulse(2'b00, 2'b01);

    // Ring mode across the top of the address space.
    ring_addr = '{16'hFFFE, 16'hFFFF, 16'h0000, 16'hFFFE, 16'hFFFF, 16'h0000, 16'hFFFE};
    cfg(0, 16'hFFFE, 16'd3, 1'b1);
    mark = log_n; dmark = dp0;
    pulse(2'b01, 2'b00);
    for (int k = 0; k < 7; k++) begin
      in_valid[0] = 1'b1;
      in_sof[0]   = (k == 0);
      in_data[7:0] = 8'hF0 + 8'(k);
      tick(1);
    end
    in_valid = '0; in_sof = '0;
    tick(8);
    chk("t4_nwrites", log_n - mark, 7);
    for (int i = 0; i < 7; i++) begin
      chk("t4_addr", log_addr[mark+i], ring_addr[i]);
      chk("t4_data", log_data[mark+i], 8'hF0 + 8'(i));
    end
    chk("t4_wraps", wrap_count[7:0], 2);
    chk("t4_pulses", dp0 - dmark, 2);
    chk("t4_done", done[0], 0);
    chk("t4_busy", busy[0], 1);
    chk("t4_bytes", bytes_written[15:0], 1);
    pulse(2'b00, 2'b01);
    chk("t4_abort_idle", busy[0], 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
